// File: rtl/timer_sched_pkg.sv
// Shared definitions for the timer scheduler: FSM encoding and a clog2 helper.
package timer_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_ACK   = 2'd3
  } sched_state_e;

  // Ceiling log2 usable in constant expressions; returns at least 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/timer.sv
// Down-counting timer: load on start, count to zero, done while the counter is zero.
module timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] count_i,
  output logic             done_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next counter value: load has priority over decrement; holds at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = count_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  // Counter register with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/timer_scheduler.sv
// Round-robin sharing of one down-counting timer among NUM_REQ delay requesters.
module timer_scheduler
  import timer_sched_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  parameter  int unsigned WIDTH   = 8,
  localparam int unsigned IDX_W   = clog2(NUM_REQ)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*WIDTH-1:0] count_i,
  output logic [NUM_REQ-1:0]       ack_o,
  output logic [NUM_REQ-1:0]       grant_o,
  output logic [IDX_W-1:0]         grant_id_o,
  output logic                     busy_o
);

  sched_state_e       state_q, state_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [IDX_W-1:0]   gid_q, gid_d;
  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               busy_q, busy_d;

  logic               timer_start_c;
  logic               timer_done;
  logic [IDX_W-1:0]   pick_c;
  logic [WIDTH-1:0]   pick_cnt_c;

  // First set request at or above ptr, wrapping; smallest circular distance wins.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] pick;
    int unsigned      best_d;
    int unsigned      d;
    pick   = ptr;
    best_d = NUM_REQ;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (req[j]) begin
        d = (j + NUM_REQ - 32'(ptr)) % NUM_REQ;
        if (d < best_d) begin
          best_d = d;
          pick   = IDX_W'(j);
        end
      end
    end
    return pick;
  endfunction

  // Grantee selection and its requested count.
  always_comb begin
    pick_c     = rr_pick(req_i, rr_q);
    pick_cnt_c = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (32'(pick_c) == j) pick_cnt_c = count_i[j*WIDTH +: WIDTH];
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    gid_d         = gid_q;
    cnt_d         = cnt_q;
    timer_start_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (|req_i) begin
          gid_d   = pick_c;
          cnt_d   = pick_cnt_c;
          state_d = ST_START;
        end
      end
      ST_START: begin
        timer_start_c = 1'b1;
        state_d       = ST_RUN;
      end
      ST_RUN: begin
        if (timer_done) state_d = ST_ACK;
      end
      ST_ACK: begin
        rr_d    = (gid_q == IDX_W'(NUM_REQ - 1)) ? '0 : gid_q + IDX_W'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d  = (state_d != ST_IDLE);
    grant_d = busy_d ? (NUM_REQ'(1) << gid_d) : '0;
    ack_d   = (state_d == ST_ACK) ? (NUM_REQ'(1) << gid_d) : '0;
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      gid_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gid_q   <= gid_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  timer #(
    .WIDTH (WIDTH)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_i   (~rst_ni),
    .start_i (timer_start_c),
    .count_i (cnt_q),
    .done_o  (timer_done)
  );

  assign ack_o      = ack_q;
  assign grant_o    = grant_q;
  assign grant_id_o = gid_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler with hand-computed cycle expectations.
module tb_timer_scheduler;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           rst_ni;
  logic [N-1:0]   req_i;
  logic [N*W-1:0] count_i;
  logic [N-1:0]   ack_o;
  logic [N-1:0]   grant_o;
  logic [1:0]     grant_id_o;
  logic           busy_o;

  int n_tests = 0;
  int n_fail  = 0;
  bit armed   = 1'b0;

  always #5 clk = ~clk;

  timer_scheduler #(
    .NUM_REQ (N),
    .WIDTH   (W)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .req_i      (req_i),
    .count_i    (count_i),
    .ack_o      (ack_o),
    .grant_o    (grant_o),
    .grant_id_o (grant_id_o),
    .busy_o     (busy_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench in the first IDLE cycle after reset (cycle 0 of a test).
  task automatic do_reset();
    rst_ni  = 1'b0;
    req_i   = '0;
    count_i = '0;
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  // Output invariants, sampled mid-cycle.
  always @(negedge clk) begin
    if (armed) begin
      check("inv_ack_onehot",   32'($onehot0(ack_o)), 32'd1);
      check("inv_grant_onehot", 32'($onehot0(grant_o)), 32'd1);
      check("inv_ack_in_grant", 32'(ack_o & ~grant_o), 32'd0);
      check("inv_busy_grant",   32'(busy_o), 32'(grant_o != '0));
    end
  end

  // Requester protocol watch: dropping a request while granted is only a warning.
  always @(negedge clk) begin
    if (armed && rst_ni) begin
      assert ((grant_o & ~req_i) == '0)
        else $warning("protocol: request withdrawn while granted");
    end
  end

  initial begin
    rst_ni  = 1'b0;
    req_i   = '0;
    count_i = '0;

    // Reset state
    do_reset();
    armed = 1'b1;
    check("rst_ack",   32'(ack_o), 32'd0);
    check("rst_grant", 32'(grant_o), 32'd0);
    check("rst_gid",   32'(grant_id_o), 32'd0);
    check("rst_busy",  32'(busy_o), 32'd0);

    // Single request, C=5: busy 1..8, ack at 8
    req_i = 4'b0001;
    count_i[0*W +: W] = 8'd5;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("single_ack",  32'(ack_o), (k == 8) ? 32'h1 : 32'h0);
      check("single_busy", 32'(busy_o), 32'd1);
      if (k == 1) check("single_grant", 32'(grant_o), 32'h1);
    end
    tick();
    req_i = '0;
    check("single_after_ack",  32'(ack_o), 32'd0);
    check("single_after_busy", 32'(busy_o), 32'd0);
    tick();
    check("single_idle", 32'(busy_o), 32'd0);

    // Zero count: ack at 3
    do_reset();
    req_i = 4'b0010;
    count_i[1*W +: W] = 8'd0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("zero_ack",  32'(ack_o), (k == 3) ? 32'h2 : 32'h0);
      check("zero_busy", 32'(busy_o), 32'd1);
    end
    tick();
    req_i = '0;
    check("zero_done_busy", 32'(busy_o), 32'd0);
    tick();

    // All-request fairness, C=2: acks 0,1,2,3 at 5,11,17,23
    do_reset();
    req_i = 4'b1111;
    for (int j = 0; j < 4; j++) count_i[j*W +: W] = 8'd2;
    for (int k = 1; k <= 24; k++) begin
      logic [31:0] exp_ack;
      tick();
      exp_ack = 32'h0;
      if (k == 5)  exp_ack = 32'h1;
      if (k == 11) exp_ack = 32'h2;
      if (k == 17) exp_ack = 32'h4;
      if (k == 23) exp_ack = 32'h8;
      check("fair_ack", 32'(ack_o), exp_ack);
      if (k == 1)  check("fair_gid0", 32'(grant_id_o), 32'd0);
      if (k == 7)  check("fair_gid1", 32'(grant_id_o), 32'd1);
      if (k == 13) check("fair_gid2", 32'(grant_id_o), 32'd2);
      if (k == 19) check("fair_gid3", 32'(grant_id_o), 32'd3);
      if (k == 6)  req_i[0] = 1'b0;
      if (k == 12) req_i[1] = 1'b0;
      if (k == 18) req_i[2] = 1'b0;
      if (k == 24) req_i[3] = 1'b0;
    end
    tick();
    check("fair_idle", 32'(busy_o), 32'd0);

    // Round-robin: req0 held (C=1), req2 raised at 2 (C=3)
    do_reset();
    req_i = 4'b0001;
    count_i[0*W +: W] = 8'd1;
    for (int k = 1; k <= 16; k++) begin
      logic [31:0] exp_ack;
      tick();
      exp_ack = 32'h0;
      if (k == 4)  exp_ack = 32'h1;
      if (k == 11) exp_ack = 32'h4;
      if (k == 16) exp_ack = 32'h1;
      check("rr_ack", 32'(ack_o), exp_ack);
      if (k == 6)  check("rr_grant2", 32'(grant_o), 32'h4);
      if (k == 12) check("rr_idle_gap", 32'(grant_o), 32'h0);
      if (k == 13) check("rr_grant0", 32'(grant_o), 32'h1);
      if (k == 2) begin
        req_i[2] = 1'b1;
        count_i[2*W +: W] = 8'd3;
      end
      if (k == 12) req_i[2] = 1'b0;
    end

    // Count latch: count changed at 3, ack still at 9
    do_reset();
    req_i = 4'b0010;
    count_i[1*W +: W] = 8'd6;
    for (int k = 1; k <= 9; k++) begin
      tick();
      check("latch_ack", 32'(ack_o), (k == 9) ? 32'h2 : 32'h0);
      if (k == 3) count_i[1*W +: W] = 8'd1;
    end
    tick();
    req_i = '0;
    check("latch_after", 32'(ack_o), 32'd0);
    tick();

    // Reset mid-run: req3 C=200, reset at 50
    do_reset();
    req_i = 4'b1000;
    count_i[3*W +: W] = 8'd200;
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (k == 1) check("midrst_gid", 32'(grant_id_o), 32'd3);
      check("midrst_run_ack",  32'(ack_o), 32'd0);
      check("midrst_run_busy", 32'(busy_o), 32'd1);
    end
    rst_ni = 1'b0;
    req_i  = '0;
    tick();
    rst_ni = 1'b1;
    check("midrst_ack",   32'(ack_o), 32'd0);
    check("midrst_grant", 32'(grant_o), 32'd0);
    check("midrst_gid0",  32'(grant_id_o), 32'd0);
    check("midrst_busy",  32'(busy_o), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("midrst_quiet_ack",  32'(ack_o), 32'd0);
      check("midrst_quiet_busy", 32'(busy_o), 32'd0);
    end
    req_i = 4'b1000;
    count_i[3*W +: W] = 8'd4;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("midrst_new_ack", 32'(ack_o), (k == 7) ? 32'h8 : 32'h0);
      if (k == 8) req_i = '0;
    end
    tick();
    check("midrst_end_busy", 32'(busy_o), 32'd0);

    armed = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
